// File: rtl/gcn_pkg.sv
// Shared sizing constants and scan FSM state type for the GCN argmax readout.
package gcn_pkg;

  localparam int unsigned NUM_OF_NODES      = 6;
  localparam int unsigned WEIGHT_COLS       = 3;
  localparam int unsigned DOT_PROD_WIDTH    = 16;
  localparam int unsigned MAX_ADDRESS_WIDTH = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/argmax_reader_if.sv
// Memory-side and result bus of argmax_reader; slave = reader, master = environment.
interface argmax_reader_if #(
  parameter int unsigned NUM_OF_NODES      = gcn_pkg::NUM_OF_NODES,
  parameter int unsigned WEIGHT_COLS       = gcn_pkg::WEIGHT_COLS,
  parameter int unsigned DOT_PROD_WIDTH    = gcn_pkg::DOT_PROD_WIDTH,
  parameter int unsigned MAX_ADDRESS_WIDTH = gcn_pkg::MAX_ADDRESS_WIDTH,
  parameter int unsigned COO_BW            = $clog2(NUM_OF_NODES)
) ();

  logic                                             start;
  logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0]       adj_fm_wm_row;
  logic [COO_BW-1:0]                                read_row_arg;
  logic [NUM_OF_NODES-1:0][MAX_ADDRESS_WIDTH-1:0]   max_addi_answer;
  logic                                             busy;
  logic                                             done;

  modport slave (
    input  start,
    input  adj_fm_wm_row,
    output read_row_arg,
    output max_addi_answer,
    output busy,
    output done
  );

  modport master (
    output start,
    output adj_fm_wm_row,
    input  read_row_arg,
    input  max_addi_answer,
    input  busy,
    input  done
  );

endinterface

// File: rtl/argmax_row.sv
// Combinational index-of-maximum over one row; lowest column wins ties.
// Build option: ARGMAX_SIGNED_EN selects two's complement comparison (default unsigned).
module argmax_row #(
  parameter int unsigned WEIGHT_COLS       = gcn_pkg::WEIGHT_COLS,
  parameter int unsigned DOT_PROD_WIDTH    = gcn_pkg::DOT_PROD_WIDTH,
  parameter int unsigned MAX_ADDRESS_WIDTH = gcn_pkg::MAX_ADDRESS_WIDTH
) (
  input  logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] i_row,
  output logic [MAX_ADDRESS_WIDTH-1:0]               o_idx
);

  function automatic logic greater(input logic [DOT_PROD_WIDTH-1:0] a,
                                   input logic [DOT_PROD_WIDTH-1:0] b);
`ifdef ARGMAX_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  logic [DOT_PROD_WIDTH-1:0] w_best;

  // Strict greater-than keeps the earliest column on equal values.
  always_comb begin
    o_idx  = '0;
    w_best = i_row[0];
    for (int unsigned c = 1; c < WEIGHT_COLS; c++) begin
      if (greater(i_row[c], w_best)) begin
        w_best = i_row[c];
        o_idx  = MAX_ADDRESS_WIDTH'(c);
      end
    end
  end

endmodule

// File: rtl/argmax_reader.sv
// Scans every FM_WM_ADJ row once per start and stores each row's argmax column.
// Build option: ARGMAX_SIGNED_EN (signed element comparison inside argmax_row).
module argmax_reader #(
  parameter int unsigned NUM_OF_NODES      = gcn_pkg::NUM_OF_NODES,
  parameter int unsigned WEIGHT_COLS       = gcn_pkg::WEIGHT_COLS,
  parameter int unsigned DOT_PROD_WIDTH    = gcn_pkg::DOT_PROD_WIDTH,
  parameter int unsigned MAX_ADDRESS_WIDTH = gcn_pkg::MAX_ADDRESS_WIDTH,
  parameter int unsigned COO_BW            = $clog2(NUM_OF_NODES)
) (
  input  logic            clk,
  input  logic            reset,
  argmax_reader_if.slave  bus
);

  import gcn_pkg::*;

  localparam int unsigned LAST_ROW = NUM_OF_NODES - 1;

  // A row must be able to name every one of its columns.
  if (WEIGHT_COLS > (1 << MAX_ADDRESS_WIDTH)) begin : g_bad_cfg
    $error("argmax_reader: WEIGHT_COLS exceeds 2**MAX_ADDRESS_WIDTH");
  end

  state_t                                          r_state;
  logic [COO_BW-1:0]                               r_row_cnt;
  logic                                            r_busy;
  logic                                            r_done;
  logic [NUM_OF_NODES-1:0][MAX_ADDRESS_WIDTH-1:0]  r_answer;
  logic [MAX_ADDRESS_WIDTH-1:0]                    w_row_idx;

  argmax_row #(
    .WEIGHT_COLS       (WEIGHT_COLS),
    .DOT_PROD_WIDTH    (DOT_PROD_WIDTH),
    .MAX_ADDRESS_WIDTH (MAX_ADDRESS_WIDTH)
  ) u_argmax_row (
    .i_row (bus.adj_fm_wm_row),
    .o_idx (w_row_idx)
  );

  // Counter idles at zero outside READ, so it doubles as the row address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_row_cnt <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_answer  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state   <= READ;
            r_row_cnt <= '0;
            r_busy    <= 1'b1;
          end
        end
        READ: begin
          r_answer[r_row_cnt] <= w_row_idx;
          if (r_row_cnt == COO_BW'(LAST_ROW)) begin
            r_row_cnt <= '0;
            r_state   <= DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
          end else begin
            r_row_cnt <= r_row_cnt + COO_BW'(1);
          end
        end
        DONE: begin
          if (!bus.start) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_row_cnt <= '0;
          r_busy    <= 1'b0;
          r_done    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.read_row_arg    = r_row_cnt;
  assign bus.max_addi_answer = r_answer;
  assign bus.busy            = r_busy;
  assign bus.done            = r_done;

endmodule

// File: tb/tb_argmax_reader.sv
// Directed and randomized scans of argmax_reader against an array-based reference model.
module tb_argmax_reader;

  localparam int unsigned N   = gcn_pkg::NUM_OF_NODES;
  localparam int unsigned WC  = gcn_pkg::WEIGHT_COLS;
  localparam int unsigned DW  = gcn_pkg::DOT_PROD_WIDTH;
  localparam int unsigned MAW = gcn_pkg::MAX_ADDRESS_WIDTH;

  typedef logic [WC-1:0][DW-1:0] row_t;

  logic clk;
  logic reset;
  row_t mem [N];
  int   ref_ans [N];
  int   n_cmp;
  int   n_mis;

  argmax_reader_if bus_if ();

  argmax_reader u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational read at the requested row.
  always_comb begin
    bus_if.adj_fm_wm_row = '0;
    if (int'(bus_if.read_row_arg) < N) bus_if.adj_fm_wm_row = mem[bus_if.read_row_arg];
  end

  function automatic row_t mk_row(input int a, input int b, input int c);
    row_t r;
    r    = '0;
    r[0] = DW'(a);
    r[1] = DW'(b);
    r[2] = DW'(c);
    return r;
  endfunction

  // Reference: first column holding the largest numeric value.
  function automatic int model_argmax(input row_t row);
    int best_val;
    int best_idx;
    int v;
    best_val = 0;
    best_idx = 0;
    for (int c = 0; c < WC; c++) begin
`ifdef ARGMAX_SIGNED_EN
      v = int'($signed(row[c]));
`else
      v = int'(row[c]);
`endif
      if (c == 0 || v > best_val) begin
        best_val = v;
        best_idx = c;
      end
    end
    return best_idx;
  endfunction

  function automatic logic [63:0] exp_vec();
    logic [63:0] v;
    v = '0;
    for (int r = 0; r < N; r++) v = v | (64'(ref_ans[r]) << (r * MAW));
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 64'(bus_if.busy), 64'(0));
    check({tag, "_done"}, 64'(bus_if.done), 64'(0));
    check({tag, "_addr"}, 64'(bus_if.read_row_arg), 64'(0));
    check({tag, "_ans"},  64'(bus_if.max_addi_answer), exp_vec());
  endtask

  // One full scan; optionally wiggles start while the scan is running.
  task automatic run_scan(input string tag, input bit wiggle);
    @(negedge clk);
    bus_if.start = 1'b1;
    @(negedge clk);
    check({tag, "_r0_busy"}, 64'(bus_if.busy), 64'(1));
    check({tag, "_r0_addr"}, 64'(bus_if.read_row_arg), 64'(0));
    check({tag, "_r0_done"}, 64'(bus_if.done), 64'(0));
    for (int r = 0; r < N; r++) begin
      if (wiggle) bus_if.start = 1'($urandom);
      @(negedge clk);
      ref_ans[r] = model_argmax(mem[r]);
      check($sformatf("%s_ans_r%0d", tag, r), 64'(bus_if.max_addi_answer), exp_vec());
      if (r < N - 1) begin
        check($sformatf("%s_busy_r%0d", tag, r + 1), 64'(bus_if.busy), 64'(1));
        check($sformatf("%s_addr_r%0d", tag, r + 1), 64'(bus_if.read_row_arg), 64'(r + 1));
        check($sformatf("%s_done_r%0d", tag, r + 1), 64'(bus_if.done), 64'(0));
      end else begin
        check({tag, "_fin_done"}, 64'(bus_if.done), 64'(1));
        check({tag, "_fin_busy"}, 64'(bus_if.busy), 64'(0));
        check({tag, "_fin_addr"}, 64'(bus_if.read_row_arg), 64'(0));
      end
    end
    bus_if.start = 1'b1;
    @(negedge clk);
    check({tag, "_hold_done"}, 64'(bus_if.done), 64'(1));
    bus_if.start = 1'b0;
    @(negedge clk);
    check_idle({tag, "_back_idle"});
  endtask

  initial begin
    n_cmp        = 0;
    n_mis        = 0;
    reset        = 1'b0;
    bus_if.start = 1'b0;
    mem[0] = mk_row(5, 2, 1);
    mem[1] = mk_row(0, 9, 3);
    mem[2] = mk_row(1, 1, 7);
    mem[3] = mk_row(4, 4, 0);
    mem[4] = mk_row(2, 2, 2);
    mem[5] = mk_row(0, 0, 1);
    for (int r = 0; r < N; r++) ref_ans[r] = 0;

    repeat (2) @(negedge clk);
    check_idle("reset");
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("post_reset");

    run_scan("basic", 1'b0);
    check("basic_const", 64'(bus_if.max_addi_answer), 64'h824);

    mem[2] = mk_row(9, 0, 0);
    run_scan("rescan", 1'b0);
    check("rescan_const", 64'(bus_if.max_addi_answer), 64'h804);

    run_scan("wiggle", 1'b1);
    check("wiggle_const", 64'(bus_if.max_addi_answer), 64'h804);

    mem[0] = mk_row(16'hFFFF, 16'h0001, 0);
    run_scan("sign", 1'b0);
`ifdef ARGMAX_SIGNED_EN
    check("sign_entry0", 64'(bus_if.max_addi_answer[0]), 64'(1));
`else
    check("sign_entry0", 64'(bus_if.max_addi_answer[0]), 64'(0));
`endif

    // Asynchronous reset while row 3 is being addressed.
    @(negedge clk);
    bus_if.start = 1'b1;
    repeat (4) @(negedge clk);
    check("mid_addr3", 64'(bus_if.read_row_arg), 64'(3));
    reset = 1'b0;
    #1;
    for (int r = 0; r < N; r++) ref_ans[r] = 0;
    check_idle("mid_reset");
    bus_if.start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("mid_released");
    run_scan("after_reset", 1'b0);

    for (int it = 0; it < 8; it++) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < WC; c++) begin
          if (it[0]) mem[r][c] = DW'($urandom_range(0, 3));
          else       mem[r][c] = DW'($urandom);
        end
      end
      run_scan($sformatf("rand%0d", it), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/argmax_reader.md
ARGMAX_READER -- requirements
Module: argmax_reader

Interface
REQ-001 SHALL have parameter NUM_OF_NODES, default 6, node/row count of the FM_WM_ADJ memory.
REQ-002 SHALL have parameter WEIGHT_COLS, default 3, class columns per row.
REQ-003 SHALL have parameter DOT_PROD_WIDTH, default 16, element width.
REQ-004 SHALL have parameter MAX_ADDRESS_WIDTH, default 2, width of one argmax result.
REQ-005 SHALL have parameter COO_BW, default $clog2(NUM_OF_NODES), row address width.
REQ-006 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-007 SHALL have port reset  input  1  one clock; reset is asynchronous and active-low.
REQ-008 SHALL have port start  input  1  level; driven by the aggregation done output.
REQ-009 SHALL have port adj_fm_wm_row  input  WEIGHT_COLS x DOT_PROD_WIDTH  row read from FM_WM_ADJ memory, combinational in read_row_arg.
REQ-010 SHALL have port read_row_arg  output  COO_BW  row address to FM_WM_ADJ memory.
REQ-011 SHALL have port max_addi_answer  output  NUM_OF_NODES x MAX_ADDRESS_WIDTH  per-node argmax column index.
REQ-012 SHALL have port busy  output  1  high in READ.
REQ-013 SHALL have port done  output  1  high in DONE.

Function
REQ-014 SHALL implement FSM states IDLE, READ, DONE; read_row_arg, busy, done decoded from registered state/row counter only.
REQ-015 IDLE: read_row_arg=0; start=1 at an edge -> READ, row counter=0.
REQ-016 READ: every edge, max_addi_answer[row] <= argmax(adj_fm_wm_row); row counter +1; read_row_arg = row counter.
REQ-017 READ at row NUM_OF_NODES-1: write result, counter returns to 0 (no overrun), -> DONE.
REQ-018 Latency: start sampled at edge k; row r written at edge k+1+r; done=1 after edge k+NUM_OF_NODES (6 cycles at defaults).
REQ-019 DONE: done=1, read_row_arg=0; stays while start=1; start=0 at an edge -> IDLE.
REQ-020 start in READ SHALL be ignored; no restart mid-scan.
REQ-021 Comparison: unsigned DOT_PROD_WIDTH values (see REQ-027); tie -> lowest column index; all equal -> 0.
REQ-022 Results SHALL persist until overwritten by a later scan or cleared by reset; unscanned entries unchanged.
REQ-023 WEIGHT_COLS > 2**MAX_ADDRESS_WIDTH SHALL be a elaboration-time error.

Reset
REQ-024 reset=0 SHALL immediately force IDLE, row counter=0, read_row_arg=0, busy=0, done=0, all max_addi_answer entries=0, regardless of state.
REQ-025 Release of reset mid-scan SHALL NOT resume; new scan requires start sampled in IDLE.
REQ-026 Reset SHALL NOT be used as synchronous data; no other clear path exists.

Configuration
REQ-027 Macro ARGMAX_SIGNED_EN: defined -> elements compared as two's complement signed; undefined -> unsigned; tie rule unchanged in both.

Structure
REQ-028 Package gcn_pkg SHALL hold NUM_OF_NODES, WEIGHT_COLS, DOT_PROD_WIDTH, MAX_ADDRESS_WIDTH constants and the FSM state enum typedef.
REQ-029 One combinational sub-module argmax_row SHALL compute the index of the max of WEIGHT_COLS elements, honouring REQ-021/REQ-027.

Verification
REQ-030 Rows {5,2,1},{0,9,3},{1,1,7},{4,4,0},{2,2,2},{0,0,1}, start held -> answers 0,1,2,0,0,2; done after 6 cycles; read_row_arg sequence 0..5.
REQ-031 Row {16'hFFFF,16'h0001,0}: unsigned build -> 0; ARGMAX_SIGNED_EN build -> 1.
REQ-032 reset=0 asserted at row 3 of a scan -> all outputs 0 same cycle; after release, start -> full rescan, correct results.
REQ-033 start pulsed low/high during READ -> scan unaffected, ends in DONE at the normal cycle; start=0 in DONE -> IDLE next edge.
REQ-034 Second scan with changed memory row 2 {9,0,0} -> only entry 2 changes to 0; done reasserts after 6 cycles.
